// File: rtl/stall_ctrl.sv
// Pipeline stall controller: picks one per-stage hold pattern from load-use, divide and
// data-SRAM wait sources, and sequences the multi-cycle divider with a timeout guard.
module stall_ctrl #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_req,
  input  logic        div_ready,
  input  logic        stallreq_mem,
  output logic [5:0]  stall,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_timeout,
  output logic [31:0] stall_cycles,
  output logic        o_dbg_state
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV_TIMEOUT - 1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_timeout;
  logic [31:0]   r_stall_cycles;
  logic          w_div_src;
  logic          w_timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_timeout_hit) r_timeout <= 1'b1;
      if ((stall != STALL_NONE) && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  // The divide source is inactive in the exit cycle (ready or timeout) so EX can capture.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_src     = 1'b0;
    w_timeout_hit = 1'b0;
    div_start     = 1'b0;
    div_busy      = 1'b0;
    stall         = STALL_NONE;

    case (r_state)
      S_IDLE: begin
        if (div_req) begin
          w_div_src   = 1'b1;
          div_start   = 1'b1;
          w_state_nxt = S_DIV;
          w_cnt_nxt   = '0;
        end
      end
      S_DIV: begin
        div_busy = 1'b1;
        if (div_ready) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt   = S_IDLE;
          w_timeout_hit = 1'b1;
        end else begin
          w_div_src = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (stallreq_mem)     stall = STALL_MEM;
    else if (w_div_src)   stall = STALL_DIV;
    else if (stallreq_id) stall = STALL_LU;

    if (rst) begin
      stall     = STALL_NONE;
      div_start = 1'b0;
      div_busy  = 1'b0;
    end
  end

  assign div_timeout  = r_timeout;
  assign stall_cycles = r_stall_cycles;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: stallreq_id  in  1  load-use hazard detected in ID this cycle.
REQ-004 SHALL have: div_req  in  1  EX holds a div/divu needing the multi-cycle divider.
REQ-005 SHALL have: div_ready  in  1  divider result valid this cycle.
REQ-006 SHALL have: stallreq_mem  in  1  data SRAM not ready for the MEM-stage access.
REQ-007 SHALL have: stall  out  6  per-stage hold; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-008 SHALL have: div_start  out  1  one-cycle pulse launching the divider.
REQ-009 SHALL have: div_busy  out  1  high while state is DIV.
REQ-010 SHALL have: div_timeout  out  1  sticky error flag.
REQ-011 SHALL have: stall_cycles  out  32  count of cycles with stall != 0.
REQ-012 SHALL have parameter DIV_TIMEOUT, default 40, meaning the maximum number of DIV-state cycles before abort.

Function
REQ-013 SHALL implement FSM states IDLE and DIV; stall SHALL be combinational (Mealy) from the current state and the current-cycle requests.
REQ-014 Stall patterns SHALL be: none 6'b000000; load-use 6'b000111; divide 6'b001111; mem-wait 6'b011111.
REQ-015 Priority SHALL be the later stage first: stallreq_mem > divide (DIV state or IDLE with div_req) > stallreq_id; the output is the pattern of the highest-priority active source only.
REQ-016 Load-use SHALL stall exactly the cycles in which stallreq_id is high, with no FSM state; the resulting bubble enters ID/EX because stall[2]=1 and stall[3]=0.
REQ-017 IDLE->DIV SHALL occur on the edge after a cycle with div_req=1 while in IDLE; div_start=1 in that same IDLE cycle only, also when stallreq_mem is high.
REQ-018 In DIV: stall SHALL be at least 6'b001111; the cycle counter SHALL increment by 1 per cycle starting from 0 on entry.
REQ-019 DIV->IDLE SHALL occur when div_ready=1; stall SHALL drop to 6'b000000 in the div_ready cycle unless stallreq_mem is high, so EX captures the result that cycle.
REQ-020 If the counter reaches DIV_TIMEOUT-1 without div_ready: go to IDLE, set div_timeout=1 (held until reset), and release stall that cycle.
REQ-021 div_ready while in IDLE SHALL be ignored, and div_start SHALL NOT be generated while in DIV.
REQ-022 A div_req in the cycle in which DIV exits SHALL NOT re-launch the divider; a new launch requires div_req high in a later IDLE cycle.
REQ-023 stallreq_mem during DIV SHALL NOT pause the counter; a div_ready arriving in that cycle SHALL still complete the transition.
REQ-024 stall_cycles SHALL increment on every edge where stall != 0 and saturate at 32'hFFFF_FFFF (no wrap).

Reset
REQ-025 While rst=1 at an edge: state SHALL become IDLE, and counter, div_timeout and stall_cycles SHALL become 0.
REQ-026 During the rst=1 cycle, stall, div_start and div_busy SHALL be 0 regardless of inputs.
REQ-027 Reset in the middle of DIV SHALL abort the division with no div_start and no timeout flag.

Verification
REQ-028 Load-use: stallreq_id=1 for 1 cycle -> stall=000111 for that cycle, 000000 next, stall_cycles=1.
REQ-029 Divide: div_req=1 in IDLE, div_ready after 33 DIV cycles -> div_start pulses once, div_busy high for 33 cycles, stall=001111 until the ready cycle, then 000000.
REQ-030 Timeout: div_req with div_ready never asserted, DIV_TIMEOUT=40 -> return to IDLE after 40 DIV cycles, div_timeout=1 and stays 1.
REQ-031 Priority: stallreq_mem=1 and stallreq_id=1 in DIV -> stall=011111; when stallreq_mem drops -> 001111.
REQ-032 Reset: rst=1 at DIV cycle 10 -> next cycle state IDLE, stall=000000, stall_cycles=0, div_timeout=0.
REQ-033 Saturation: preload stall_cycles to 32'hFFFF_FFFE, then hold a stall for 3 cycles -> stall_cycles reads 32'hFFFF_FFFF.
